// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
//   state_e : sequencer states
//   ctrl_t  : bundle of register write enables and bubble (flush) strobes
//   OP_*    : opcodes the decode stage recognises (HLT drives fd_halt)
//   NOP_INSTR : encoding loaded into a pipeline register on a flush
package pipe_ctrl_pkg;

    localparam int REG_W = 4;

    localparam logic [3:0]  OP_HLT    = 4'hF;
    localparam logic [3:0]  OP_LW     = 4'h8;
    localparam logic [3:0]  OP_SW     = 4'h9;
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        DRAIN,
        HALTED
    } state_e;

    typedef struct packed {
        logic pc_en;
        logic fd_en;
        logic de_en;
        logic xm_en;
        logic mw_en;
        logic fd_flush;
        logic de_flush;
        logic mw_flush;
    } ctrl_t;

    // Free-running pipeline: every register advances, nothing is squashed.
    localparam ctrl_t CTRL_FLOW = '{pc_en: 1'b1, fd_en: 1'b1, de_en: 1'b1, xm_en: 1'b1,
                                    mw_en: 1'b1, fd_flush: 1'b0, de_flush: 1'b0,
                                    mw_flush: 1'b0};

    // Data-memory stall: everything up to XM holds, MW takes a bubble so the
    // stalled access is not retired twice.
    localparam ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, fd_en: 1'b0, de_en: 1'b0, xm_en: 1'b0,
                                      mw_en: 1'b1, fd_flush: 1'b0, de_flush: 1'b0,
                                      mw_flush: 1'b1};

    localparam ctrl_t CTRL_STOP = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare (purely combinational).
//   fd_rs, fd_rt         : source registers of the instruction in decode
//   fd_uses_rs/rt        : decode instruction really reads that source
//   de_mem_read          : instruction in execute is a load
//   de_write_reg         : destination of the instruction in execute
//   load_use             : decode needs a value the load has not produced yet
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] fd_rs,
    input  logic [REG_W-1:0] fd_rt,
    input  logic             fd_uses_rs,
    input  logic             fd_uses_rt,
    input  logic             de_mem_read,
    input  logic [REG_W-1:0] de_write_reg,
    output logic             load_use
);

    logic rs_match;
    logic rt_match;

    assign rs_match = fd_uses_rs && (fd_rs == de_write_reg);
    assign rt_match = fd_uses_rt && (fd_rt == de_write_reg);

    // R0 is hard-wired to zero, so a load targeting it never creates a dependency.
    assign load_use = de_mem_read && (de_write_reg != '0) && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline.
//   clk, rst               : clock, asynchronous active-low reset
//   fd_* / de_* / ex_*     : hazard sources from decode and execute
//   xm_mem_req, mem_ready  : multi-cycle data-memory handshake
//   pc_en..mw_en           : pipeline register write enables (Mealy)
//   fd/de/mw_flush         : load a bubble into that register (Mealy)
//   halted, mem_err        : drained-and-stopped, sticky memory timeout
//   stall_cnt              : saturating count of cycles with PC held in RUN/MEM_WAIT
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT  = 64,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] fd_rs,
    input  logic [REG_W-1:0] fd_rt,
    input  logic             fd_uses_rs,
    input  logic             fd_uses_rt,
    input  logic             fd_halt,
    input  logic             de_mem_read,
    input  logic [REG_W-1:0] de_write_reg,
    input  logic             ex_branch_taken,
    input  logic             xm_mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             fd_en,
    output logic             de_en,
    output logic             xm_en,
    output logic             mw_en,
    output logic             fd_flush,
    output logic             de_flush,
    output logic             mw_flush,
    output logic             halted,
    output logic             mem_err,
    output logic [15:0]      stall_cnt
);

    localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    state_e             state_q,   state_d;
    logic [WAIT_W-1:0]  wait_q,    wait_d;
    logic [DRAIN_W-1:0] drain_q,   drain_d;
    logic               mem_err_q, mem_err_d;
    logic [15:0]        stall_q,   stall_d;

    ctrl_t ctrl;
    logic  load_use;
    logic  mem_stall;

    hazard_detect u_hazard_detect (
        .fd_rs        (fd_rs),
        .fd_rt        (fd_rt),
        .fd_uses_rs   (fd_uses_rs),
        .fd_uses_rt   (fd_uses_rt),
        .de_mem_read  (de_mem_read),
        .de_write_reg (de_write_reg),
        .load_use     (load_use)
    );

    assign mem_stall = xm_mem_req && !mem_ready;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        ctrl      = CTRL_FLOW;
        state_d   = state_q;
        wait_d    = wait_q;
        drain_d   = drain_q;
        mem_err_d = mem_err_q;

        unique case (state_q)
            RUN, MEM_WAIT: begin
                if (mem_stall) begin
                    ctrl = CTRL_FREEZE;
                    if (state_q == RUN) begin
                        // The detecting cycle is already the first wait cycle.
                        state_d = MEM_WAIT;
                        wait_d  = WAIT_W'(1);
                    end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        state_d   = HALTED;
                        mem_err_d = 1'b1;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end else begin
                    // Ready cycle of a memory wait is treated exactly like RUN,
                    // so a branch held in execute is applied right here.
                    state_d = RUN;
                    wait_d  = '0;
                    if (ex_branch_taken) begin
                        // Squashes the decode instruction, including a HLT.
                        ctrl.fd_flush = 1'b1;
                        ctrl.de_flush = 1'b1;
                    end else if (fd_halt) begin
                        ctrl.pc_en    = 1'b0;
                        ctrl.fd_flush = 1'b1;
                        drain_d       = DRAIN_W'(DRAIN_CYCLES - 1);
                        state_d       = DRAIN;
                    end else if (load_use) begin
                        ctrl.pc_en    = 1'b0;
                        ctrl.fd_en    = 1'b0;
                        ctrl.de_flush = 1'b1;
                    end
                end
            end

            DRAIN: begin
                if (mem_stall) begin
                    ctrl = CTRL_FREEZE;
                end else begin
                    ctrl.pc_en    = 1'b0;
                    ctrl.fd_flush = 1'b1;
                    ctrl.de_flush = 1'b1;
                    if (drain_q == '0) begin
                        state_d = HALTED;
                    end else begin
                        drain_d = drain_q - 1'b1;
                    end
                end
            end

            HALTED: begin
                ctrl = CTRL_STOP;
            end
        endcase

        stall_d = stall_q;
        if ((state_q == RUN || state_q == MEM_WAIT) && !ctrl.pc_en && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            wait_q    <= '0;
            drain_q   <= '0;
            mem_err_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            drain_q   <= drain_d;
            mem_err_q <= mem_err_d;
            stall_q   <= stall_d;
        end
    end

    assign pc_en     = ctrl.pc_en;
    assign fd_en     = ctrl.fd_en;
    assign de_en     = ctrl.de_en;
    assign xm_en     = ctrl.xm_en;
    assign mw_en     = ctrl.mw_en;
    assign fd_flush  = ctrl.fd_flush;
    assign de_flush  = ctrl.de_flush;
    assign mw_flush  = ctrl.mw_flush;
    assign halted    = (state_q == HALTED);
    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed scenarios followed by
// randomized stimulus compared against a cycle-level behavioural model.
module tb_pipeline_stall_ctrl;

    localparam int MEM_TIMEOUT  = 8;
    localparam int DRAIN_CYCLES = 3;

    // Expected control vectors, ordered {pc,fd,de,xm,mw, fd_fl,de_fl,mw_fl}.
    localparam logic [7:0] E_FLOW   = 8'b11111_000;
    localparam logic [7:0] E_FREEZE = 8'b00001_001;
    localparam logic [7:0] E_BRANCH = 8'b11111_110;
    localparam logic [7:0] E_HALT   = 8'b01111_100;
    localparam logic [7:0] E_LDUSE  = 8'b00111_010;
    localparam logic [7:0] E_DRAIN  = 8'b01111_110;
    localparam logic [7:0] E_STOP   = 8'b00000_000;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  fd_rs, fd_rt, de_write_reg;
    logic        fd_uses_rs, fd_uses_rt, fd_halt, de_mem_read;
    logic        ex_branch_taken, xm_mem_req, mem_ready;
    logic        pc_en, fd_en, de_en, xm_en, mw_en;
    logic        fd_flush, de_flush, mw_flush;
    logic        halted, mem_err;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(
        .MEM_TIMEOUT  (MEM_TIMEOUT),
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fd_rs           (fd_rs),
        .fd_rt           (fd_rt),
        .fd_uses_rs      (fd_uses_rs),
        .fd_uses_rt      (fd_uses_rt),
        .fd_halt         (fd_halt),
        .de_mem_read     (de_mem_read),
        .de_write_reg    (de_write_reg),
        .ex_branch_taken (ex_branch_taken),
        .xm_mem_req      (xm_mem_req),
        .mem_ready       (mem_ready),
        .pc_en           (pc_en),
        .fd_en           (fd_en),
        .de_en           (de_en),
        .xm_en           (xm_en),
        .mw_en           (mw_en),
        .fd_flush        (fd_flush),
        .de_flush        (de_flush),
        .mw_flush        (mw_flush),
        .halted          (halted),
        .mem_err         (mem_err),
        .stall_cnt       (stall_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: tracks "how many cycles frozen so far", "how many
    // drain cycles still owed", and whether the pipeline has stopped.
    bit m_halted;
    bit m_err;
    int m_stalls;
    int m_frozen;
    int m_drain_left;

    task automatic model_reset();
        m_halted     = 1'b0;
        m_err        = 1'b0;
        m_stalls     = 0;
        m_frozen     = 0;
        m_drain_left = 0;
    endtask

    // Returns the controls expected this cycle and advances the model one edge.
    task automatic model_step(output logic [7:0] e);
        bit mem_stall;
        bit hazard;
        bit running;
        mem_stall = xm_mem_req && !mem_ready;
        hazard    = de_mem_read && de_write_reg != 0 &&
                    ((fd_uses_rs && fd_rs == de_write_reg) || (fd_uses_rt && fd_rt == de_write_reg));
        running   = !m_halted && m_drain_left == 0;
        e = E_STOP;
        if (m_halted) begin
            e = E_STOP;
        end else if (m_drain_left > 0) begin
            if (mem_stall) e = E_FREEZE;
            else begin
                e = E_DRAIN;
                m_drain_left--;
                if (m_drain_left == 0) m_halted = 1'b1;
            end
        end else if (mem_stall) begin
            e = E_FREEZE;
            m_frozen++;
            if (m_frozen == MEM_TIMEOUT) begin
                m_err    = 1'b1;
                m_halted = 1'b1;
            end
        end else begin
            m_frozen = 0;
            if (ex_branch_taken) e = E_BRANCH;
            else if (fd_halt) begin
                e = E_HALT;
                m_drain_left = DRAIN_CYCLES;
            end else if (hazard) e = E_LDUSE;
            else e = E_FLOW;
        end
        if (running && !e[7] && m_stalls < 65535) m_stalls++;
    endtask

    function automatic logic [7:0] dut_ctrl();
        return {pc_en, fd_en, de_en, xm_en, mw_en, fd_flush, de_flush, mw_flush};
    endfunction

    task automatic set_idle();
        fd_rs = 4'd0; fd_rt = 4'd0; fd_uses_rs = 1'b0; fd_uses_rt = 1'b0;
        fd_halt = 1'b0; de_mem_read = 1'b0; de_write_reg = 4'd0;
        ex_branch_taken = 1'b0; xm_mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // Called shortly after a rising edge with inputs already driven.
    task automatic tick(input string tag);
        logic [7:0] e;
        #1;
        check({tag, "_halted"}, 32'(halted), 32'(m_halted));
        check({tag, "_mem_err"}, 32'(mem_err), 32'(m_err));
        check({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(m_stalls));
        model_step(e);
        check({tag, "_ctrl"}, 32'(dut_ctrl()), 32'(e));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b0;
        #2;
        model_reset();
        check("reset_ctrl", 32'(dut_ctrl()), 32'(E_FLOW));
        check("reset_halted", 32'(halted), 32'd0);
        check("reset_cnt", 32'(stall_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        #1;
        do_reset();
        check("reset_mem_err", 32'(mem_err), 32'd0);

        // Load-use on R3: one bubble, then a clean cycle.
        de_mem_read = 1'b1; de_write_reg = 4'd3; fd_rs = 4'd3; fd_uses_rs = 1'b1;
        tick("lu");
        check("lu_cnt", 32'(stall_cnt), 32'd1);
        set_idle();
        tick("lu_after");

        // A load into R0 is not a dependency.
        de_mem_read = 1'b1; de_write_reg = 4'd0; fd_rs = 4'd0; fd_uses_rs = 1'b1;
        tick("r0");
        check("r0_cnt", 32'(stall_cnt), 32'd1);

        // Branch squashes a same-cycle HLT.
        set_idle();
        ex_branch_taken = 1'b1; fd_halt = 1'b1;
        tick("br_hlt");
        set_idle();
        repeat (5) tick("br_hlt_after");
        check("br_hlt_not_halted", 32'(halted), 32'd0);

        // Four-cycle memory wait with a pending branch.
        do_reset();
        xm_mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
        repeat (4) tick("mw_wait");
        mem_ready = 1'b1;
        tick("mw_ready");
        check("mw_cnt", 32'(stall_cnt), 32'd4);
        set_idle();
        tick("mw_after");

        // Memory timeout: error and halt, both sticky until reset.
        do_reset();
        xm_mem_req = 1'b1; mem_ready = 1'b0;
        repeat (MEM_TIMEOUT) tick("to_wait");
        check("to_halted", 32'(halted), 32'd1);
        check("to_err", 32'(mem_err), 32'd1);
        set_idle();
        mem_ready = 1'b1;
        repeat (3) tick("to_sticky");
        do_reset();
        check("to_err_cleared", 32'(mem_err), 32'd0);

        // Halt, drain, halted.
        fd_halt = 1'b1;
        tick("hlt");
        set_idle();
        repeat (DRAIN_CYCLES) tick("drain");
        check("drain_halted", 32'(halted), 32'd1);
        tick("halted_idle");

        // Halt, then reset asynchronously in the middle of the drain.
        do_reset();
        fd_halt = 1'b1;
        tick("hlt2");
        set_idle();
        tick("drain2");
        rst = 1'b0;
        #1;
        model_reset();
        check("midrst_ctrl", 32'(dut_ctrl()), 32'(E_FLOW));
        check("midrst_cnt", 32'(stall_cnt), 32'd0);
        check("midrst_halted", 32'(halted), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick("post_rst");

        // Randomized segments; every third segment hammers the memory handshake.
        for (int seg = 0; seg < 30; seg++) begin
            do_reset();
            for (int cyc = 0; cyc < 80; cyc++) begin
                fd_rs           = 4'($urandom_range(0, 3));
                fd_rt           = 4'($urandom_range(0, 3));
                de_write_reg    = 4'($urandom_range(0, 3));
                fd_uses_rs      = ($urandom_range(0, 1) == 1);
                fd_uses_rt      = ($urandom_range(0, 1) == 1);
                de_mem_read     = ($urandom_range(0, 1) == 1);
                ex_branch_taken = ($urandom_range(0, 7) == 0);
                fd_halt         = ($urandom_range(0, 39) == 0);
                if (seg % 3 == 2) begin
                    xm_mem_req = 1'b1;
                    mem_ready  = ($urandom_range(0, 5) == 0);
                end else begin
                    xm_mem_req = ($urandom_range(0, 2) == 0);
                    mem_ready  = ($urandom_range(0, 1) == 1);
                end
                tick("rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central stall/flush sequencer for the five-stage pipeline. It drives the write-enable and bubble (flush) inputs of the PC, fetch/decode, decode/execute, execute/memory and memory/writeback registers. It decides them from load-use hazards, taken branches, a multi-cycle data-memory handshake and the halt instruction. It also keeps a saturating stall-cycle counter and a memory-timeout error flag.

## Interface
Parameters:
- MEM_TIMEOUT, 64: maximum consecutive MEM_WAIT cycles before mem_err is raised and the block halts.
- DRAIN_CYCLES, 3: bubble cycles issued after a halt is accepted (DE, XM, MW).

Ports (name, direction, width, meaning):
- clk  input  1  single clock. Everything is on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- fd_rs, fd_rt  input  4 each  source register addresses of the instruction in decode.
- fd_uses_rs, fd_uses_rt  input  1 each  decode instruction actually reads that source.
- fd_halt  input  1  the decode instruction is HLT (opcode 4'hF).
- de_mem_read  input  1  the instruction in execute is a load.
- de_write_reg  input  4  destination register of the instruction in execute.
- ex_branch_taken  input  1  branch resolved taken in execute.
- xm_mem_req  input  1  the memory-stage instruction accesses data memory.
- mem_ready  input  1  data memory completes the access this cycle.
- pc_en, fd_en, de_en, xm_en, mw_en  output  1 each  register write enables.
- fd_flush, de_flush, mw_flush  output  1 each  load a bubble: control bits cleared, instruction = NOP.
- halted  output  1  pipeline drained and stopped.
- mem_err  output  1  sticky memory-timeout error.
- stall_cnt  output  16  saturating count of stall cycles.

## Operation
States: RUN, MEM_WAIT, DRAIN, HALTED.

Hazard priority, highest first: memory wait > branch > halt > load-use.

**RUN**
- Memory wait: xm_mem_req & !mem_ready.
  - pc_en, fd_en, de_en, xm_en = 0; mw_flush = 1.
  - Next state is MEM_WAIT.
- Branch: ex_branch_taken.
  - fd_flush = 1 and de_flush = 1; all enables = 1.
  - Stay in RUN. A same-cycle fd_halt is squashed and ignored.
- Halt: fd_halt and no branch.
  - pc_en = 0 and fd_flush = 1.
  - Load the drain counter with DRAIN_CYCLES-1; next state is DRAIN.
- Load-use:
  - Condition: de_mem_read & de_write_reg != 0 & ((fd_uses_rs & fd_rs == de_write_reg) | (fd_uses_rt & fd_rt == de_write_reg)).
  - Response: pc_en = 0, fd_en = 0, de_flush = 1; other enables = 1.
  - Lasts exactly one cycle.
- Otherwise: all enables = 1 and all flushes = 0.

**MEM_WAIT**
- Holds the freeze outputs of a memory wait.
- A wait counter increments every cycle.
- If mem_ready = 1: this cycle behaves like RUN with no memory hazard. A pending ex_branch_taken is applied in this same cycle. Next state is RUN and the wait counter clears.
- If the wait counter reaches MEM_TIMEOUT-1 without mem_ready: mem_err is set, next state is HALTED.

**DRAIN**
- pc_en = 0, fd_flush = 1, de_flush = 1.
- de_en, xm_en, mw_en = 1, so in-flight instructions complete.
- xm_mem_req & !mem_ready still freezes the pipeline exactly as in MEM_WAIT, and the drain counter holds.
- The drain counter decrements when not frozen. At 0, next state is HALTED.

**HALTED**
- All enables = 0, all flushes = 0, halted = 1.
- Leaves only on reset.

**stall_cnt**
- Increments in any cycle where pc_en = 0 in RUN or MEM_WAIT.
- Saturates at 16'hFFFF.
- Does not count in DRAIN or HALTED.

## Timing
- Enable and flush outputs are Mealy: combinational from the registered state plus current inputs. They take effect at the next rising edge.
- State, counters, halted, mem_err and stall_cnt are registered.
- Reset (rst = 0, asynchronous) puts the block in:
  - state RUN
  - stall_cnt = 0, mem_err = 0, halted = 0
  - drain and wait counters = 0
- With idle inputs during and immediately after reset: all enables = 1, all flushes = 0.
- Reset asserted mid-MEM_WAIT or mid-DRAIN aborts the sequence immediately. No residual stall is allowed on the first post-reset cycle.
- Latencies:
  - Load-use costs 1 bubble.
  - A taken branch costs 2 bubbles.
  - Memory wait adds N cycles for N cycles of !mem_ready.
  - halted rises DRAIN_CYCLES + 1 cycles after the halt is accepted, plus any memory-wait cycles.
- mem_ready = 1 on the same cycle as xm_mem_req: no stall.

## Structure
- Package pipe_ctrl_pkg:
  - state enum {RUN, MEM_WAIT, DRAIN, HALTED}
  - OP_HLT = 4'hF, OP_LW = 4'h8, OP_SW = 4'h9
  - NOP instruction constant
- Sub-module hazard_detect: purely combinational load-use compare, output load_use.
- Top level holds the FSM, the wait/drain counters and stall_cnt.

## Test plan
- Load-use: de_mem_read = 1, de_write_reg = 3, fd_rs = 3, fd_uses_rs = 1 → for one cycle pc_en = 0, fd_en = 0, de_flush = 1; stall_cnt = 1. The next cycle is clean.
- Destination R0: same as above with de_write_reg = 0 and fd_rs = 0 → no stall.
- Branch vs halt: ex_branch_taken = 1 with fd_halt = 1 → fd_flush = de_flush = 1, state stays RUN, halted never rises.
- Memory wait: xm_mem_req = 1, mem_ready low for 4 cycles, branch pending → 4 frozen cycles with mw_flush = 1. On the ready cycle, fd_flush = de_flush = 1. stall_cnt = 4.
- Memory timeout with MEM_TIMEOUT = 8: mem_ready never asserted → mem_err = 1 and halted = 1 after 8 cycles. Both persist until rst = 0.
- Halt drain, then reset mid-drain: halt → 3 drain cycles → halted = 1. Repeat with rst pulsed low during drain → immediate RUN, stall_cnt = 0, all enables = 1.
